// File: rtl/fll_ctrl.sv
// fll_ctrl: FLL controller, SAR search of the oscillator DAC code then +/-1 LSB tracking with lock and saturation flags
module fll_ctrl #(
  parameter int CODE_W     = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  target,
  output logic              meas_req,
  input  logic              meas_ack,
  input  logic [CNT_W-1:0]  meas_count,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              locked,
  output logic              sat
);
  localparam int IW = CODE_W > 1 ? $clog2(CODE_W) : 1;
  localparam int SW = SETTLE_CYC > 0 ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W+1:0] TOL_X = (CNT_W + 2)'(TOL);
  typedef enum logic [1:0] {IDLE, SETTLE, MEAS} state_t;
  state_t state, state_nx;
  logic              track;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     scnt;
  logic [LW-1:0]     icnt;
  logic [CNT_W-1:0]  tgt;
  logic [CODE_W-1:0] sar_code;
  logic              eval, below, above;
  assign eval  = state == MEAS && meas_ack && !stop;
  assign below = {2'b0, meas_count} + TOL_X < {2'b0, tgt};
  assign above = {2'b0, meas_count} > {2'b0, tgt} + TOL_X;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: stop beats a same-cycle ack, start only counts in IDLE
  always_comb
    state_nx = state == IDLE ? (start ? SETTLE : IDLE) :
               stop ? IDLE :
               state == SETTLE ? (scnt == '0 ? MEAS : SETTLE) :
               (meas_ack ? SETTLE : MEAS);
  // outputs decoded from state
  always_comb begin
    busy     = state != IDLE;
    meas_req = state == MEAS;
  end
  // SAR trial: drop the current bit if too fast, then try the next lower bit
  always_comb begin
    sar_code = code;
    if (meas_count > tgt) sar_code[idx] = 1'b0;
    if (idx != '0) sar_code[idx - 1'b1] = 1'b1;
  end
  // datapath: settle timer, SAR/track code updates, lock and saturation flags
  always_ff @(posedge clk)
    if (rst) begin
      code   <= '0;
      track  <= 1'b0;
      idx    <= '0;
      scnt   <= '0;
      icnt   <= '0;
      tgt    <= '0;
      locked <= 1'b0;
      sat    <= 1'b0;
    end else begin
      scnt <= state != SETTLE ? SW'(SETTLE_CYC) : scnt - 1'b1;
      if (state == IDLE && start) begin
        tgt    <= target;
        code   <= CODE_W'(1) << (CODE_W - 1);
        idx    <= IW'(CODE_W - 1);
        track  <= 1'b0;
        sat    <= 1'b0;
        locked <= 1'b0;
        icnt   <= '0;
      end else if (state != IDLE && stop) begin
        locked <= 1'b0;
      end else if (eval && !track) begin
        code <= sar_code;
        if (idx == '0) track <= 1'b1;
        else idx <= idx - 1'b1;
      end else if (eval && !below && !above) begin
        icnt <= icnt == LW'(LOCK_CNT) ? icnt : icnt + 1'b1;
        if (int'(icnt) + 1 >= LOCK_CNT) locked <= 1'b1;
      end else if (eval) begin
        icnt   <= '0;
        locked <= 1'b0;
        if ((below && &code) || (above && code == '0)) sat <= 1'b1;
        else code <= below ? code + 1'b1 : code - 1'b1;
      end
    end
endmodule

// File: doc/fll_ctrl.md
# fll_ctrl

Digital frequency-locked-loop controller for the supply-controlled ring oscillator in the simple PLL. It drives the oscillator's supply-DAC code. It sequences settle/measure cycles against an external edge-count measurement unit. It first runs a successive-approximation (SAR) search over the code, then tracks with ±1 LSB steps and flags lock. The block sits between the reference-clock measurement block and the VDD DAC that feeds the oscillator.

## Interface

Parameters:
- CODE_W, 8: width of DAC code driving oscillator supply (monotonic: higher code → higher frequency).
- CNT_W, 16: width of measured edge count and target.
- SETTLE_CYC, 16: wait cycles after every code change before requesting a measurement (≥0).
- TOL, 2: lock dead band; in-band means |count − target| ≤ TOL.
- LOCK_CNT, 4: consecutive in-band TRACK measurements required to assert locked (≥1).

Ports:
- clk  in  1  reference clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level; sampled only in IDLE; begins acquisition.
- stop  in  1  level; from any non-IDLE state, returns to IDLE next cycle.
- target  in  CNT_W  desired edge count per measurement window; sampled on start.
- meas_req  out  1  measurement request.
- meas_ack  in  1  measurement done; meas_count valid in the same cycle.
- meas_count  in  CNT_W  unsigned oscillator edge count.
- code  out  CODE_W  DAC code (registered).
- busy  out  1  high in any state except IDLE.
- locked  out  1  lock indicator.
- sat  out  1  sticky: TRACK requested a step beyond code 0 or 2^CODE_W−1.

## Operation

- States: IDLE, SETTLE, MEAS. Internal mode bit: SAR or TRACK. Bit index idx (log2 CODE_W bits). Settle counter. In-band counter (saturates at LOCK_CNT). Latched target.
- IDLE: code holds its last value.
  - On start=1: latch target; code ← 1<<(CODE_W−1); idx ← CODE_W−1; mode ← SAR; clear sat, locked, in-band count; → SETTLE.
- SETTLE: load SETTLE_CYC on entry; decrement each cycle; when counter==0 → MEAS.
- MEAS: meas_req=1 until a cycle with meas_ack=1. On that edge: meas_req ← 0, evaluate, → SETTLE. meas_ack is ignored outside MEAS.
- SAR evaluation (unsigned compare):
  - If meas_count > target, clear code[idx]; otherwise keep it.
  - If idx==0: mode ← TRACK.
  - Else: idx−1, and set code[idx−1].
- TRACK evaluation (signed error = count − target, CNT_W+1 bits):
  - In band: code unchanged; in-band count +1. When it reaches LOCK_CNT, locked ← 1.
  - Error < −TOL: code +1. Error > TOL: code −1. In-band count ← 0; locked ← 0.
  - If a step would pass 0 or max: code holds and sat ← 1. The loop keeps running.
- stop: → IDLE; meas_req ← 0; locked ← 0; code and sat hold. stop has priority over a same-cycle meas_ack, and that measurement is discarded.
- start while busy: ignored. target changes while busy: ignored.

## Timing

- Reset values: code=0, meas_req=0, busy=0, locked=0, sat=0, state IDLE, mode SAR.
- start sampled at edge N: code=MSB-only and busy=1 after edge N. meas_req rises after edge N+SETTLE_CYC+1.
- Every code update is followed by exactly SETTLE_CYC+1 cycles with meas_req=0 before meas_req rises.
- meas_ack at edge M: meas_req=0 and the new code are visible after edge M. meas_ack may arrive the same cycle meas_req rises, or any number of cycles later.
- SAR takes exactly CODE_W measurements. The first TRACK measurement follows the last SAR update.
- locked rises on the edge evaluating the LOCK_CNT-th consecutive in-band measurement. It falls on the first out-of-band evaluation, on stop, or on rst.
- rst mid-measurement: all outputs return to reset values next cycle. A late meas_ack is ignored.

## Test plan

- Linear model count=100+4·code, target=612, SETTLE_CYC=16, ack 3 cycles after req → SAR ends at code=128; locked=1 after 4 TRACK measurements; sat=0.
- Same model, target=613, TOL=0 → SAR gives 128 (count 612). TRACK then alternates 128↔129 and locked never rises. With TOL=2, locks at 128.
- Floor model count=max(250, 4·code), target=100 → code reaches 0. TRACK error > TOL with code 0 → sat=1, code stays 0, locked=0.
- Ack latency randomized 0–20 cycles, including ack in the same cycle req rises → identical final code. meas_req is low for exactly SETTLE_CYC+1 cycles after each code change.
- stop asserted in the same cycle as meas_ack during SAR → IDLE next cycle; code frozen; measurement discarded. A later start restarts from code=128.
- rst pulsed while meas_req=1 → all outputs reset next cycle. A subsequent meas_ack while in IDLE causes no change.
